// File: rtl/universal_register.sv
// universal_register: WIDTH-bit datapath register with load, shift, rotate and
// up/down count selected per cycle by mode. Registered carry/shift-out flag and a
// combinational zero flag.
module universal_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SATURATE    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync_clear,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic             serial_in,
  output logic [WIDTH-1:0] out_data,
  output logic             carry_out,
  output logic             zero
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_INC  = 3'b110;
  localparam logic [2:0] M_DEC  = 3'b111;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] nxt_data;
  logic             nxt_carry;
  logic             at_max;
  logic             at_min;

  assign at_max = (out_data == ALL_ONES);
  assign at_min = (out_data == '0);

  // Next-state word and flag for an enabled operation; every mode code is covered.
  always_comb begin
    nxt_data  = out_data;
    nxt_carry = 1'b0;
    case (mode)
      M_HOLD: begin
        nxt_data  = out_data;
        nxt_carry = 1'b0;
      end
      M_LOAD: begin
        nxt_data  = in_data;
        nxt_carry = 1'b0;
      end
      M_SHL: begin
        nxt_data  = {out_data[WIDTH-2:0], serial_in};
        nxt_carry = out_data[WIDTH-1];
      end
      M_SHR: begin
        nxt_data  = {serial_in, out_data[WIDTH-1:1]};
        nxt_carry = out_data[0];
      end
      M_ROL: begin
        nxt_data  = {out_data[WIDTH-2:0], out_data[WIDTH-1]};
        nxt_carry = out_data[WIDTH-1];
      end
      M_ROR: begin
        nxt_data  = {out_data[0], out_data[WIDTH-1:1]};
        nxt_carry = out_data[0];
      end
      M_INC: begin
        // Saturating counters clamp at all-ones but still flag the overflow attempt.
        nxt_data  = (SATURATE && at_max) ? out_data : out_data + 1'b1;
        nxt_carry = at_max;
      end
      M_DEC: begin
        nxt_data  = (SATURATE && at_min) ? out_data : out_data - 1'b1;
        nxt_carry = at_min;
      end
      default: begin
        nxt_data  = out_data;
        nxt_carry = 1'b0;
      end
    endcase
  end

  // State register: async reset, then sync clear, then enabled update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= RESET_VALUE;
      carry_out <= 1'b0;
    end else if (sync_clear) begin
      out_data  <= RESET_VALUE;
      carry_out <= 1'b0;
    end else if (enable) begin
      out_data  <= nxt_data;
      carry_out <= nxt_carry;
    end
  end

  assign zero = (out_data == '0);

endmodule

// File: tb/tb_universal_register.sv
// Bench for universal_register: three instances (wrap, saturate, RESET_VALUE=0x10)
// share stimulus; an arithmetic reference model is compared every negedge, plus
// directed literal checks.
module tb_universal_register;

  logic       clk;
  logic       reset;
  logic       sync_clear;
  logic       enable;
  logic [2:0] mode;
  logic [7:0] in_data;
  logic       serial_in;
  logic [7:0] od [3];
  logic       cy [3];
  logic       zr [3];

  localparam bit       SAT [3] = '{1'b0, 1'b1, 1'b0};
  localparam int       RV  [3] = '{0, 0, 'h10};

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  int mv [3];
  bit mc [3];

  universal_register #(.WIDTH(8), .RESET_VALUE(8'h00), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .sync_clear(sync_clear), .enable(enable), .mode(mode),
    .in_data(in_data), .serial_in(serial_in), .out_data(od[0]), .carry_out(cy[0]), .zero(zr[0]));
  universal_register #(.WIDTH(8), .RESET_VALUE(8'h00), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .sync_clear(sync_clear), .enable(enable), .mode(mode),
    .in_data(in_data), .serial_in(serial_in), .out_data(od[1]), .carry_out(cy[1]), .zero(zr[1]));
  universal_register #(.WIDTH(8), .RESET_VALUE(8'h10), .SATURATE(1'b0)) u_rv (
    .clk(clk), .reset(reset), .sync_clear(sync_clear), .enable(enable), .mode(mode),
    .in_data(in_data), .serial_in(serial_in), .out_data(od[2]), .carry_out(cy[2]), .zero(zr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Operation semantics as plain unsigned arithmetic on 0..255.
  function automatic void step(input int old, input bit sat, input int m, input int d,
                               input int s, output int nv, output bit nc);
    nv = old; nc = 0;
    case (m)
      0: begin nv = old; nc = 0; end
      1: begin nv = d; nc = 0; end
      2: begin nv = (old * 2 + s) % 256; nc = (old >= 128); end
      3: begin nv = old / 2 + s * 128; nc = (old % 2 == 1); end
      4: begin nv = (old * 2) % 256 + old / 128; nc = (old >= 128); end
      5: begin nv = old / 2 + (old % 2) * 128; nc = (old % 2 == 1); end
      6: begin
        if (sat && old == 255) begin nv = 255; nc = 1; end
        else begin nv = (old + 1) % 256; nc = (old == 255); end
      end
      default: begin
        if (sat && old == 0) begin nv = 0; nc = 1; end
        else begin nv = (old + 255) % 256; nc = (old == 0); end
      end
    endcase
  endfunction

  // Reference model update.
  always @(posedge clk or posedge reset) begin
    int nv;
    bit nc;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        mv[i] <= RV[i]; mc[i] <= 0;
      end else if (sync_clear) begin
        mv[i] <= RV[i]; mc[i] <= 0;
      end else if (enable) begin
        step(mv[i], SAT[i], int'(mode), int'(in_data), int'(serial_in), nv, nc);
        mv[i] <= nv; mc[i] <= nc;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model data[%0d]", i), int'(od[i]), mv[i]);
        chk($sformatf("model carry[%0d]", i), int'(cy[i]), int'(mc[i]));
        chk($sformatf("model zero[%0d]", i), int'(zr[i]), int'(mv[i] == 0));
      end
    end
  end

  task automatic op(input logic [2:0] m, input logic [7:0] d = 8'h00, input logic s = 1'b0,
                    input logic en = 1'b1, input logic sc = 1'b0);
    mode = m; in_data = d; serial_in = s; enable = en; sync_clear = sc;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; sync_clear = 0; enable = 0; mode = 0; in_data = 0; serial_in = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset data", od[0], 8'h00);
    chk("reset carry", cy[0], 0);
    chk("reset zero", zr[0], 1);
    chk("reset rv data", od[2], 8'h10);
    @(negedge clk); #1 reset = 1'b0;
    chk_en = 1;

    // 1: mid-cycle reset after a load
    op(3'b001, 8'hA5);
    chk("t1 load", od[0], 8'hA5);
    #2 reset = 1'b1;
    #1;
    chk("t1 async data", od[0], 8'h00);
    chk("t1 async carry", cy[0], 0);
    chk("t1 async zero", zr[0], 1);
    @(negedge clk); #1 reset = 1'b0;

    // 2: shifts
    op(3'b001, 8'h81);
    op(3'b010, 8'h00, 1'b0);
    chk("t2 shl data", od[0], 8'h02);
    chk("t2 shl carry", cy[0], 1);
    op(3'b011, 8'h00, 1'b1);
    chk("t2 shr data", od[0], 8'h81);
    chk("t2 shr carry", cy[0], 0);

    // 3: rotates
    op(3'b001, 8'h01);
    op(3'b101);
    chk("t3 ror data", od[0], 8'h80);
    chk("t3 ror carry", cy[0], 1);
    op(3'b100);
    chk("t3 rol data", od[0], 8'h01);
    chk("t3 rol carry", cy[0], 1);

    // 4: wrap vs saturate
    op(3'b001, 8'hFF);
    op(3'b110);
    chk("t4 inc wrap data", od[0], 8'h00);
    chk("t4 inc wrap carry", cy[0], 1);
    chk("t4 inc wrap zero", zr[0], 1);
    chk("t4 inc sat data", od[1], 8'hFF);
    chk("t4 inc sat carry", cy[1], 1);
    op(3'b111);
    chk("t4 dec wrap data", od[0], 8'hFF);
    chk("t4 dec wrap carry", cy[0], 1);

    // 5: enable low holds, sync_clear overrides
    op(3'b001, 8'h3C);
    repeat (5) op(3'b110, 8'h00, 1'b0, 1'b0);
    chk("t5 hold data", od[0], 8'h3C);
    chk("t5 hold carry", cy[0], 0);
    op(3'b001, 8'h77, 1'b0, 1'b1, 1'b1);
    chk("t5 clear data", od[0], 8'h00);
    chk("t5 clear carry", cy[0], 0);
    chk("t5 clear rv data", od[2], 8'h10);

    // 6: count down from RESET_VALUE=0x10
    #1 reset = 1'b1;
    #1;
    chk("t6 reset rv", od[2], 8'h10);
    chk("t6 reset rv zero", zr[2], 0);
    @(negedge clk); #1 reset = 1'b0;
    repeat (16) op(3'b111);
    chk("t6 dec16 data", od[2], 8'h00);
    chk("t6 dec16 zero", zr[2], 1);
    op(3'b111);
    chk("t6 dec17 data", od[2], 8'hFF);
    chk("t6 dec17 carry", cy[2], 1);

    // Random traffic, biased toward counter boundaries
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] d;
      case ($urandom_range(0, 3))
        0: d = 8'h00;
        1: d = 8'hFF;
        default: d = 8'($urandom);
      endcase
      op(3'($urandom_range(0, 7)), d, 1'($urandom),
         1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 39) == 0));
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1; #1 reset = 1'b0;
      end
    end

    @(negedge clk); #1;
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
